// File: rtl/aidc_lite_comp_pkg.sv
// aidc_lite_comp_pkg: block geometry, header layout and FSM state set shared
// by the zero-word-elimination compressor files.
package aidc_lite_comp_pkg;
  localparam int BLK_WORDS      = 16;
  localparam int WORD_W         = 64;
  localparam int ADDR_W         = 4;
  localparam int OUT_W          = 32;
  localparam int RPTR_W         = 6;
  localparam int HDR_BITMAP_LSB = 0;
  localparam int HDR_CNT_LSB    = 16;
  localparam int HDR_CNT_W      = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_LAST = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  function automatic logic [OUT_W-1:0] make_hdr(input logic [HDR_CNT_W-1:0] cnt,
                                                input logic [BLK_WORDS-1:0] bm);
    logic [OUT_W-1:0] h;
    h = '0;
    h[HDR_BITMAP_LSB +: BLK_WORDS] = bm;
    h[HDR_CNT_LSB +: HDR_CNT_W]    = cnt;
    return h;
  endfunction
endpackage

// File: rtl/aidc_lite_comp_if.sv
// aidc_lite_comp_if: start/pop handshake, buffer read port and statistics of
// the compressor; slave = compressor core, master = engine/buffer side.
interface aidc_lite_comp_if;
  import aidc_lite_comp_pkg::*;

  logic                 start_i;
  logic                 ready_o;
  logic                 buf_rden_o;
  logic [ADDR_W-1:0]    buf_raddr_o;
  logic [WORD_W-1:0]    buf_rdata_i;
  logic                 rden_i;
  logic [OUT_W-1:0]     rdata_o;
  logic [31:0]          stat_blk_o;
  logic [31:0]          stat_zero_o;

  modport slave (
    input  start_i, buf_rdata_i, rden_i,
    output ready_o, buf_rden_o, buf_raddr_o, rdata_o, stat_blk_o, stat_zero_o
  );

  modport master (
    output start_i, buf_rdata_i, rden_i,
    input  ready_o, buf_rden_o, buf_raddr_o, rdata_o, stat_blk_o, stat_zero_o
  );
endinterface

// File: rtl/aidc_lite_comp_ser.sv
// aidc_lite_comp_ser: holds the packed nonzero words and serializes header plus
// words as a 32-bit show-ahead stream, low half of each word first.
module aidc_lite_comp_ser
  import aidc_lite_comp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_idx,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  out_en,
  input  logic                  pop,
  input  logic [HDR_CNT_W-1:0]  nz_cnt,
  input  logic [BLK_WORDS-1:0]  bitmap,
  output logic [OUT_W-1:0]      rdata,
  output logic                  last
);
  logic [WORD_W-1:0]   store [BLK_WORDS];
  logic [RPTR_W-1:0]   rptr;
  logic [RPTR_W-2:0]   rptr_m1;
  logic [WORD_W-1:0]   sel_word;

  always_ff @(posedge clk) begin
    if (wr_en) store[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rptr <= '0;
    else if (clr)            rptr <= '0;
    else if (out_en && pop)  rptr <= rptr + 6'd1;
  end

  // word j>=1 maps to store[(j-1)>>1]; (j-1) odd selects the upper half
  assign rptr_m1  = rptr[RPTR_W-2:0] - 5'd1;
  assign sel_word = store[rptr_m1[4:1]];
  assign last     = (rptr == {nz_cnt, 1'b0});

  always_comb begin
    rdata = '0;
    if (out_en) begin
      if (rptr == '0)      rdata = make_hdr(nz_cnt, bitmap);
      else if (rptr_m1[0]) rdata = sel_word[63:32];
      else                 rdata = sel_word[31:0];
    end
  end
endmodule

// File: rtl/aidc_lite_comp_core.sv
// aidc_lite_comp_core: zero-word-elimination compressor for one 16x64-bit block.
// Saturating block / zero-word counters are built only with AIDC_LITE_COMP_STAT_EN.
module aidc_lite_comp_core
  import aidc_lite_comp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  aidc_lite_comp_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start_i
  // SCAN  | issuing buffer reads 0..15, capturing each return one cycle later
  // LAST  | capturing the word for address 15
  // OUT   | header and packed words popped by the engine
  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_SCAN = 2'(S_SCAN);
  localparam logic [1:0] ST_LAST = 2'(S_LAST);
  localparam logic [1:0] ST_OUT  = 2'(S_OUT);

  logic [1:0]           state;
  logic                 rd_en_q;
  logic [ADDR_W-1:0]    raddr_q;
  logic                 cap_vld;
  logic [ADDR_W-1:0]    cap_idx;
  logic [BLK_WORDS-1:0] bitmap;
  logic [HDR_CNT_W-1:0] nz_cnt;
  logic                 ready_q;
  logic                 capture;
  logic                 word_nz;
  logic                 start_acc;
  logic                 out_en;
  logic                 last;
  logic                 final_pop;

  assign word_nz   = |bus.buf_rdata_i;
  assign capture   = cap_vld && ((state == ST_SCAN) || (state == ST_LAST));
  assign start_acc = (state == ST_IDLE) && bus.start_i;
  assign out_en    = (state == ST_OUT);
  assign final_pop = out_en && bus.rden_i && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rd_en_q <= 1'b0;
      raddr_q <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
      bitmap  <= '0;
      nz_cnt  <= '0;
      ready_q <= 1'b0;
    end else begin
      // read data returns one cycle after the address, so track what is in flight
      cap_vld <= rd_en_q;
      cap_idx <= raddr_q;
      case (state)
        ST_IDLE: if (bus.start_i) begin
          state   <= ST_SCAN;
          rd_en_q <= 1'b1;
          raddr_q <= '0;
          bitmap  <= '0;
          nz_cnt  <= '0;
        end
        ST_SCAN: begin
          if (raddr_q == 4'(BLK_WORDS - 1)) begin
            state   <= ST_LAST;
            rd_en_q <= 1'b0;
            raddr_q <= '0;
          end else begin
            raddr_q <= raddr_q + 4'd1;
          end
        end
        ST_LAST: begin
          state   <= ST_OUT;
          ready_q <= 1'b1;
        end
        ST_OUT: if (final_pop) begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      if (capture) begin
        bitmap[cap_idx] <= word_nz;
        if (word_nz) nz_cnt <= nz_cnt + 5'd1;
      end
    end
  end

  aidc_lite_comp_ser u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_acc),
    .wr_en   (capture && word_nz),
    .wr_idx  (nz_cnt[ADDR_W-1:0]),
    .wr_data (bus.buf_rdata_i),
    .out_en  (out_en),
    .pop     (bus.rden_i),
    .nz_cnt  (nz_cnt),
    .bitmap  (bitmap),
    .rdata   (bus.rdata_o),
    .last    (last)
  );

  assign bus.ready_o     = ready_q;
  assign bus.buf_rden_o  = rd_en_q;
  assign bus.buf_raddr_o = raddr_q;

`ifdef AIDC_LITE_COMP_STAT_EN
  logic [31:0] stat_blk;
  logic [31:0] stat_zero;
  logic [32:0] zero_sum;

  assign zero_sum = {1'b0, stat_zero} + 33'(5'd16 - nz_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_blk  <= '0;
      stat_zero <= '0;
    end else if (final_pop) begin
      if (stat_blk != '1) stat_blk <= stat_blk + 32'd1;
      stat_zero <= zero_sum[32] ? '1 : zero_sum[31:0];
    end
  end

  assign bus.stat_blk_o  = stat_blk;
  assign bus.stat_zero_o = stat_zero;
`else
  assign bus.stat_blk_o  = '0;
  assign bus.stat_zero_o = '0;
`endif
endmodule
